sd_fifo_bufhead_s: RTL and testbench
====================================

Name: sd_fifo_bufhead_s

Overview:
Producer-side head for the "S" FIFO family. It accepts words on a srdy/drdy consumer interface into a 2-entry skid buffer. Words are drained into an external flop/memory array through a registered write port. The write pointer (wrptr_head) is published to the paired tail only after a programmable commit delay, so the tail never reads a location before its write has landed. Single clock only; no async/gray-code mode.

Parameters:
depth, 16, FIFO memory depth in words; power of 2
width, 8, data word width
wr_lat, 1, cycles from the wr_en cycle to wrptr_head reflecting that write; legal range 1..4
asz, $clog2(depth), address width; derived, not overridden

Ports:
clk  input  1  clock, posedge
reset  input  1  asynchronous reset, active-high
c_srdy  input  1  upstream word valid
c_drdy  output  1  block can accept a word this cycle
c_data  input  width  upstream word
wr_en  output  1  memory write strobe; registered
wr_addr  output  asz  memory write address; registered
wr_data  output  width  memory write data; registered
wrptr_head  output  asz+1  committed write pointer to the tail, with wrap bit; registered
rdptr_tail  input  asz+1  read pointer from the tail, same clock domain
c_usage  output  asz+1  words in memory, from the internal pointer; registered

Behaviour:
- Reset (async, active-high): skid count = 0, wrptr_int = 0, delay pipe = 0, wrptr_head = 0, wr_en = 0, wr_addr = 0, wr_data = 0, c_usage = 0, c_drdy = 0.
- Skid buffer:
  - 2 entries, circular; head and tail pointers are 1 bit each; count is 0..2.
  - Accept = c_srdy & c_drdy; writes c_data at the skid tail.
  - c_drdy is a flop with next value = (nxt_count < 2). It depends on state only, with no combinational path from c_srdy.
  - After reset release, c_drdy = 1 from the first clock edge.
- Full: mem_full = (wrptr_int[asz-1:0] == rdptr_tail[asz-1:0]) & (wrptr_int[asz] != rdptr_tail[asz]).
- Drain condition: (count > 0) & !mem_full. At the next edge:
  - wr_en <= 1, wr_addr <= wrptr_int[asz-1:0], wr_data <= skid head word.
  - wrptr_int <= wrptr_int + 1, modulo 2^(asz+1).
  - Skid head advances.
  - Otherwise wr_en <= 0; wr_addr and wr_data hold.
- Accept and drain in the same cycle: count unchanged. Full streaming is 1 word/cycle with c_drdy held 1.
- Accept with count = 0 and memory not full: the word enters the skid and drains next cycle; minimum c_data-to-wr_en latency is 2 cycles.
- Pointer commit:
  - wrptr_head is wrptr_int delayed through a wr_lat-stage register pipe.
  - A write whose wr_en is high in cycle N appears on wrptr_head in cycle N+wr_lat.
- c_usage <= nxt_wrptr_int - rdptr_tail, modulo 2^(asz+1), every cycle.
  - Range 0..depth.
  - Skid contents are excluded.
- Full boundary:
  - When full, draining stops; the skid fills to 2 and c_drdy falls.
  - A rdptr_tail advance of k allows exactly k further writes, starting the cycle after the advance is visible.
- Wrap-around:
  - wr_addr wraps depth-1 -> 0.
  - wrptr_int[asz] toggles on each wrap.
  - Full/empty are distinguished solely by the wrap bit.
- Ordering: words are written in strict acceptance order; no drops, no duplicates.
- Reset mid-operation: all in-flight skid words and pending pipe pointers are discarded. wr_en drops immediately (asynchronously), with no partial write.
- X-safety: c_data is ignored when c_srdy = 0. rdptr_tail must be reset-consistent with this block.

Test Plan:
- Fill with the tail frozen (depth=16, rdptr_tail=0), c_srdy held high:
  - exactly 18 words accepted;
  - c_drdy = 0 from the cycle after the 18th accept;
  - c_usage = 16;
  - wr_addr sequence 0..15;
  - wrptr_head = 5'b10000 wr_lat cycles after the last wr_en.
- Latency, wr_lat=1 then wr_lat=3: single word 0xA5 accepted in cycle T:
  - wr_en = 1 with wr_addr = 0 and wr_data = 0xA5 in cycle T+2;
  - wrptr_head = 1 in cycle T+3 (wr_lat=1) or T+5 (wr_lat=3).
- Streaming with the tail reading every cycle, 40 words:
  - c_drdy stays 1 after the first cycle;
  - one wr_en per cycle;
  - wr_addr wraps 15 -> 0 twice;
  - wrptr_head[asz] toggles;
  - data sequence matches the input exactly.
- Full release: in the full state, advance rdptr_tail by 1 -> exactly one wr_en at the old read address, and the 19th word is accepted the following cycle.
- Reset mid-burst: after 5 accepts with 2 still in the skid, assert reset asynchronously:
  - wr_en, c_drdy, wrptr_head, c_usage = 0 immediately;
  - after release, the next word is written at wr_addr = 0.
- Randomised c_srdy and rdptr_tail advance, 1000 words: scoreboard shows in-order, lossless delivery; c_usage never exceeds 16; wrptr_head never precedes a wr_en.

Source files
------------

// File: rtl/sd_fifo_bufhead_s.sv
// Producer-side head of the "S" FIFO. A 2-entry skid buffer feeds an external memory through a
// registered write port; the write pointer reaches the tail only after a wr_lat-stage commit delay.

module sd_fifo_bufhead_s #(
    parameter  int depth  = 16,
    parameter  int width  = 8,
    parameter  int wr_lat = 1,
    localparam int asz    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    output logic             wr_en,
    output logic [asz-1:0]   wr_addr,
    output logic [width-1:0] wr_data,
    output logic [asz:0]     wrptr_head,
    input  logic [asz:0]     rdptr_tail,
    output logic [asz:0]     c_usage
);

    logic [width-1:0] skid_q [2];
    logic             skid_hd_q;
    logic             skid_tl_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             c_drdy_q;
    logic [asz:0]     wrptr_int_q;
    logic [asz:0]     wrptr_int_d;
    logic [asz:0]     pipe_q [wr_lat];
    logic             wr_en_q;
    logic [asz-1:0]   wr_addr_q;
    logic [width-1:0] wr_data_q;
    logic [asz:0]     c_usage_q;

    logic accept;
    logic mem_full;
    logic drain;

    always_comb begin
        // NOTE: every signal is assigned on every pass through this block, so no latch can be inferred.
        accept      = c_srdy & c_drdy_q;
        mem_full    = (wrptr_int_q[asz-1:0] == rdptr_tail[asz-1:0]) &
                      (wrptr_int_q[asz] != rdptr_tail[asz]);
        drain       = (count_q != 2'd0) & ~mem_full;
        wrptr_int_d = wrptr_int_q + {{asz{1'b0}}, drain};
        count_d     = count_q + {1'b0, accept} - {1'b0, drain};
    end

    // NOTE: skid storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            skid_q[skid_tl_q] <= c_data;
        end
    end

    // Ready is registered from the next occupancy, so c_srdy never reaches c_drdy combinationally.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            skid_hd_q   <= 1'b0;
            skid_tl_q   <= 1'b0;
            count_q     <= 2'd0;
            c_drdy_q    <= 1'b0;
            wrptr_int_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            c_usage_q   <= '0;
        end else begin
            count_q     <= count_d;
            c_drdy_q    <= (count_d < 2'd2);
            wrptr_int_q <= wrptr_int_d;
            wr_en_q     <= drain;
            c_usage_q   <= wrptr_int_d - rdptr_tail;
            if (accept) begin
                skid_tl_q <= ~skid_tl_q;
            end
            if (drain) begin
                skid_hd_q <= ~skid_hd_q;
                wr_addr_q <= wrptr_int_q[asz-1:0];
                wr_data_q <= skid_q[skid_hd_q];
            end
        end
    end

    // Commit pipe: the tail sees a write pointer only wr_lat cycles after its write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < wr_lat; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= wrptr_int_q;
            for (int i = 1; i < wr_lat; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign c_drdy     = c_drdy_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wrptr_head = pipe_q[wr_lat-1];
    assign c_usage    = c_usage_q;

endmodule

// File: tb/tb_sd_fifo_bufhead_s.sv
// Self-checking bench for sd_fifo_bufhead_s: two instances (commit delay 1 and 3) share stimulus and
// are compared every cycle against a queue-based model, plus directed literal checks.
`timescale 1ns/1ps

module tb_sd_fifo_bufhead_s;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int ASZ   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             c_srdy = 1'b0;
    logic [WIDTH-1:0] c_data = '0;
    logic [ASZ:0]     rdptr_tail = '0;

    logic             c_drdy1, wr_en1, c_drdy3, wr_en3;
    logic [ASZ-1:0]   wr_addr1, wr_addr3;
    logic [WIDTH-1:0] wr_data1, wr_data3;
    logic [ASZ:0]     head1, head3, usage1, usage3;

    sd_fifo_bufhead_s #(.depth(DEPTH), .width(WIDTH), .wr_lat(1)) u_dut1 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy1), .c_data(c_data),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wrptr_head(head1),
        .rdptr_tail(rdptr_tail), .c_usage(usage1)
    );

    sd_fifo_bufhead_s #(.depth(DEPTH), .width(WIDTH), .wr_lat(3)) u_dut3 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy3), .c_data(c_data),
        .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3), .wrptr_head(head3),
        .rdptr_tail(rdptr_tail), .c_usage(usage3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: skid as a queue, memory pointer as a modular counter, commit as a history line.
    logic [WIDTH-1:0] m_skid [$];
    logic [ASZ:0]     m_ptr;
    logic             m_drdy;
    logic             m_wr_en;
    logic [ASZ-1:0]   m_wr_addr;
    logic [WIDTH-1:0] m_wr_data;
    logic [ASZ:0]     m_usage;
    logic [ASZ:0]     m_hist [5];
    logic             m_last_acc;
    int               m_acc_cnt = 0;

    task automatic model_reset();
        m_skid.delete();
        m_ptr      = '0;
        m_drdy     = 1'b0;
        m_wr_en    = 1'b0;
        m_wr_addr  = '0;
        m_wr_data  = '0;
        m_usage    = '0;
        m_last_acc = 1'b0;
        for (int k = 0; k < 5; k++) m_hist[k] = '0;
    endtask

    task automatic model_step();
        logic full, acc, drn;
        full = (5'(m_ptr - rdptr_tail) == 5'(DEPTH));
        acc  = c_srdy && m_drdy;
        drn  = (m_skid.size() > 0) && !full;
        m_wr_en = drn;
        if (drn) begin
            m_wr_addr = m_ptr[ASZ-1:0];
            m_wr_data = m_skid.pop_front();
            m_ptr     = m_ptr + 5'd1;
        end
        if (acc) begin
            m_skid.push_back(c_data);
            m_acc_cnt++;
        end
        m_last_acc = acc;
        m_drdy     = (m_skid.size() < 2);
        m_usage    = m_ptr - rdptr_tail;
        for (int k = 4; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_ptr;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en && !reset) begin
                check("drdy_w1",    32'(c_drdy1),  32'(m_drdy));
                check("wr_en_w1",   32'(wr_en1),   32'(m_wr_en));
                check("wr_addr_w1", 32'(wr_addr1), 32'(m_wr_addr));
                check("wr_data_w1", 32'(wr_data1), 32'(m_wr_data));
                check("usage_w1",   32'(usage1),   32'(m_usage));
                check("head_w1",    32'(head1),    32'(m_hist[1]));
                check("drdy_w3",    32'(c_drdy3),  32'(m_drdy));
                check("wr_en_w3",   32'(wr_en3),   32'(m_wr_en));
                check("wr_addr_w3", 32'(wr_addr3), 32'(m_wr_addr));
                check("wr_data_w3", 32'(wr_data3), 32'(m_wr_data));
                check("usage_w3",   32'(usage3),   32'(m_usage));
                check("head_w3",    32'(head3),    32'(m_hist[3]));
                check("usage_bound", 32'(usage1 <= 5'(DEPTH)), 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        c_srdy     = 1'b0;
        rdptr_tail = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    initial begin
        #1_500_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_sim();
    end

    initial begin
        int acc, nwr, wraps, drop, gaps, tog1, tog3, budget, base;
        bit chk_next, prev1, prev3;

        // Fill with the tail frozen at 0.
        do_reset();
        c_srdy = 1'b1;
        c_data = WIDTH'($urandom);
        acc = 0; nwr = 0; chk_next = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (chk_next) begin
                check("fill_drdy_low", 32'(c_drdy1), 32'd0);
                chk_next = 1'b0;
            end
            if (c_srdy && c_drdy1) begin
                acc++;
                if (acc == 18) chk_next = 1'b1;
            end
            if (wr_en1) begin
                check("fill_addr_seq", 32'(wr_addr1), 32'(nwr % DEPTH));
                nwr++;
            end
            step();
            if (m_last_acc) c_data = WIDTH'($urandom);
        end
        check("fill_accepts", 32'(acc), 32'd18);
        check("fill_writes", 32'(nwr), 32'd16);
        check("fill_usage", 32'(usage1), 32'd16);
        check("fill_last_addr", 32'(wr_addr1), 32'd15);
        check("fill_head_w1", 32'(head1), 32'b10000);
        check("fill_head_w3", 32'(head3), 32'b10000);

        // Full release: tail advances by one.
        rdptr_tail = 5'd1;
        acc = 0; nwr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wr_en1) begin
                nwr++;
                check("release_wr_cycle", 32'(i), 32'd1);
                check("release_addr", 32'(wr_addr1), 32'd0);
            end
            if (c_srdy && c_drdy1) begin
                acc++;
                check("release_accept_cycle", 32'(i), 32'd1);
            end
            step();
            if (m_last_acc) c_data = WIDTH'($urandom);
        end
        check("release_writes", 32'(nwr), 32'd1);
        check("release_accepts", 32'(acc), 32'd1);

        // Latency of a single word through both commit delays.
        do_reset();
        step();
        c_srdy = 1'b1;
        c_data = 8'hA5;
        step();
        c_srdy = 1'b0;
        c_data = WIDTH'($urandom);
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk);
            check("lat_wr_en_w1", 32'(wr_en1), 32'(t == 2));
            check("lat_wr_en_w3", 32'(wr_en3), 32'(t == 2));
            if (t == 2) begin
                check("lat_addr", 32'(wr_addr1), 32'd0);
                check("lat_data_w1", 32'(wr_data1), 32'hA5);
                check("lat_data_w3", 32'(wr_data3), 32'hA5);
            end
            check("lat_head_w1", 32'(head1), 32'(t >= 3));
            check("lat_head_w3", 32'(head3), 32'(t >= 5));
        end

        // Streaming with the tail consuming every committed word.
        do_reset();
        c_data = '0;
        c_srdy = 1'b1;
        base = 0; nwr = 0; wraps = 0; drop = 0; gaps = 0; tog1 = 0; tog3 = 0; budget = 0;
        prev1 = 1'b0; prev3 = 1'b0;
        step();
        while (budget < 60) begin
            @(negedge clk);
            if (!c_drdy1) drop++;
            if (wr_en1) begin
                if (nwr > 0 && wr_addr1 == '0) wraps++;
                check("stream_data", 32'(wr_data1), 32'(nwr));
                nwr++;
            end else if (nwr > 0 && nwr < 40) begin
                gaps++;
            end
            if (head1[ASZ] != prev1) tog1++;
            if (head3[ASZ] != prev3) tog3++;
            prev1 = head1[ASZ];
            prev3 = head3[ASZ];
            step();
            if (m_last_acc) begin
                base++;
                c_data = WIDTH'(base);
                if (base == 40) c_srdy = 1'b0;
            end
            rdptr_tail = m_hist[3];
            budget++;
        end
        check("stream_writes", 32'(nwr), 32'd40);
        check("stream_wraps", 32'(wraps), 32'd2);
        check("stream_drdy_drops", 32'(drop), 32'd0);
        check("stream_gaps", 32'(gaps), 32'd0);
        check("stream_head_toggle_w1", 32'(tog1), 32'd2);
        check("stream_head_toggle_w3", 32'(tog3), 32'd2);

        // Reset mid-burst with two words still in the skid.
        do_reset();
        c_srdy = 1'b1;
        c_data = WIDTH'($urandom);
        base = m_acc_cnt; budget = 0;
        while (m_acc_cnt - base < 13 && budget < 100) begin
            step();
            if (m_last_acc) c_data = WIDTH'($urandom);
            budget++;
        end
        c_srdy = 1'b0;
        repeat (4) step();
        check("rst_pre_usage13", 32'(usage1), 32'd13);
        c_srdy = 1'b1;
        base = m_acc_cnt; budget = 0;
        while (m_acc_cnt - base < 5 && budget < 100) begin
            step();
            if (m_last_acc) c_data = WIDTH'($urandom);
            budget++;
        end
        c_srdy = 1'b0;
        check("rst_burst_budget", 32'(m_acc_cnt - base), 32'd5);
        check("rst_pre_usage16", 32'(usage1), 32'd16);
        check("rst_pre_head", 32'(head1), 32'd16);
        #1 reset = 1'b1;
        #1;
        check("rst_wr_en", 32'(wr_en1), 32'd0);
        check("rst_drdy", 32'(c_drdy1), 32'd0);
        check("rst_head_w1", 32'(head1), 32'd0);
        check("rst_head_w3", 32'(head3), 32'd0);
        check("rst_usage", 32'(usage1), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        c_srdy = 1'b1;
        c_data = 8'h3C;
        step();
        c_srdy = 1'b0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!wr_en1 && budget < 10);
        check("post_rst_wr_seen", 32'(wr_en1), 32'd1);
        check("post_rst_addr", 32'(wr_addr1), 32'd0);
        check("post_rst_data", 32'(wr_data1), 32'h3C);
        // A live write strobe must drop the moment reset is asserted.
        #1 reset = 1'b1;
        #1;
        check("rst_live_wr_en_w1", 32'(wr_en1), 32'd0);
        check("rst_live_wr_en_w3", 32'(wr_en3), 32'd0);

        // Randomised producer and tail, 1000 words.
        do_reset();
        base = m_acc_cnt; nwr = 0; budget = 0;
        while ((m_acc_cnt - base < 1000 || nwr < 1000) && budget < 20000) begin
            logic [ASZ:0] avail;
            @(negedge clk);
            if (wr_en1) nwr++;
            step();
            if (m_last_acc || !c_srdy) c_data = WIDTH'($urandom);
            c_srdy = (m_acc_cnt - base < 1000) && ($urandom_range(0, 3) != 0);
            avail = m_hist[3] - rdptr_tail;
            if ((budget % 200) >= 60 && avail != '0 && $urandom_range(0, 2) != 0) begin
                rdptr_tail = rdptr_tail + 5'($urandom_range(1, int'(avail)));
            end
            budget++;
        end
        c_srdy = 1'b0;
        check("rand_accepts", 32'(m_acc_cnt - base), 32'd1000);
        check("rand_writes", 32'(nwr), 32'd1000);
        check("rand_budget", 32'(budget < 20000), 32'd1);

        repeat (4) step();
        finish_sim();
    end

endmodule
